// File: rtl/top_pkg.sv
// Shared defaults and helpers for the LED blinker.
//
// Holds the default clock frequency, blink half-period and debounce window,
// plus a width helper used to size the counters.
package top_pkg;

  // 25 MHz board clock.
  localparam int unsigned CLK_FREQ_HZ_DEF     = 25_000_000;
  // 1 Hz blink: half a second high, half a second low.
  localparam int unsigned HALF_PERIOD_DEF     = 12_500_000;
  // 10 ms stability window.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250_000;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce.sv
// Level debouncer for an already-synchronized input.
//
// The output level follows din only after din has differed from it for
// DEBOUNCE_CYCLES consecutive rising edges; any sample equal to the current
// level restarts the count.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   din   - synchronized input level
//   dout  - debounced level
module debounce
  import top_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned    CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (din != level_q) begin
      if (cnt_q == CntLast) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
        level_d = din;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/top.sv
// LED blinker with synchronized (and optionally debounced) enable.
//
// Input a passes through a two-flop synchronizer. While the resulting enable
// is high, y blinks with HALF_PERIOD cycles high then HALF_PERIOD cycles low,
// always starting with a full high half-period. While the enable is low,
// y is held low and the blink state is cleared.
//
// Optional feature: define TOP_DEBOUNCE_EN to insert a debounce stage between
// the synchronizer and the blink logic.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   a     - asynchronous blink-enable level
//   y     - registered LED drive
module top
  import top_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = CLK_FREQ_HZ_DEF,
  parameter int unsigned HALF_PERIOD     = HALF_PERIOD_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic y
);

  localparam int unsigned     CntW    = cnt_width(HALF_PERIOD);
  localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

  // Reject configurations outside the legal ranges at elaboration.
  if (CLK_FREQ_HZ == 0 || HALF_PERIOD < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("top: illegal parameter value");
  end

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            en;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic            y_q, y_d;

`ifdef TOP_DEBOUNCE_EN
  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (s2_q),
    .dout (en)
  );
`else
  assign en = s2_q;
`endif

  always_comb begin
    s1_d    = a;
    s2_d    = s1_q;
    cnt_d   = '0;
    phase_d = 1'b1;
    // y reflects the phase seen this cycle, so it rises on the first enabled edge.
    y_d     = en & phase_q;
    if (en) begin
      phase_d = phase_q;
      if (cnt_q == CntLast) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      y_q     <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: two instances (HALF_PERIOD 4 and 2) share
// stimulus and are compared every cycle against a behavioural model.
module tb_top;

  localparam int unsigned Hp4 = 4;
  localparam int unsigned Hp2 = 2;
  localparam int unsigned Deb = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic y4, y2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  top #(
    .CLK_FREQ_HZ    (25_000_000),
    .HALF_PERIOD    (Hp4),
    .DEBOUNCE_CYCLES(Deb)
  ) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .y    (y4)
  );

  top #(
    .CLK_FREQ_HZ    (25_000_000),
    .HALF_PERIOD    (Hp2),
    .DEBOUNCE_CYCLES(Deb)
  ) u_dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .y    (y2)
  );

  // Model: a is seen by the blinker two edges late (plus optional debounce);
  // y is high during the even-numbered half-periods of an enabled run.
  bit m_s1, m_s2, m_lvl, m_en, m_y4, m_y2;
  int m_run;
  bit m_hist[$];

  function automatic bit blink(input bit en_now, input int run, input int hp);
    if (!en_now) return 1'b0;
    return (((run - 1) / hp) % 2) == 0;
  endfunction

  function automatic void model_edge(input bit r, input bit av);
    bit all_diff;
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_en = 0; m_y4 = 0; m_y2 = 0; m_run = 0;
      m_hist.delete();
    end else begin
      m_y4 = blink(m_en, m_run, Hp4);
      m_y2 = blink(m_en, m_run, Hp2);
      m_hist.push_back(m_s2);
      if (m_hist.size() > Deb) void'(m_hist.pop_front());
      all_diff = (m_hist.size() == Deb);
      foreach (m_hist[i]) if (m_hist[i] == m_lvl) all_diff = 0;
      if (all_diff) m_lvl = ~m_lvl;
      m_s2 = m_s1;
      m_s1 = av;
`ifdef TOP_DEBOUNCE_EN
      m_en = m_lvl;
`else
      m_en = m_s2;
`endif
      m_run = m_en ? m_run + 1 : 0;
    end
  endfunction

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive inputs for one edge, then compare both DUTs just after it.
  task automatic step(input string tag, input bit r, input bit av);
    rst_n = r;
    a     = av;
    @(posedge clk);
    #1;
    model_edge(r, av);
    check_eq({tag, "_hp4"}, y4, m_y4);
    check_eq({tag, "_hp2"}, y2, m_y2);
  endtask

  task automatic run(input string tag, input bit av, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, av);
  endtask

  initial begin
    // Reset with a held high: y stays low.
    for (int i = 0; i < 2; i++) begin
      step("reset", 1'b0, 1'b1);
      check_eq("reset_y4_low", y4, 1'b0);
      check_eq("reset_y2_low", y2, 1'b0);
    end

    // Blink timing from reset release; HP=2 instance covers wrap-around.
    run("blink", 1'b1, 24);

    // Disable during the second high cycle, then re-enable.
    step("reset2", 1'b0, 1'b0);
`ifdef TOP_DEBOUNCE_EN
    run("pre_dis", 1'b1, 7);
`else
    run("pre_dis", 1'b1, 4);
`endif
    run("disable", 1'b0, 10);
    run("reenable", 1'b1, 14);
    run("idle", 1'b0, 8);

    // Short pulses: filtered by the debouncer, passed through without it.
    run("pulse", 1'b1, 2);
    run("pulse_gap", 1'b0, 8);
    run("pulse1", 1'b1, 1);
    run("pulse1_gap", 1'b0, 6);

    // Reset during the low half of a blink with a held high.
    run("pre_rst", 1'b1, 9);
    step("mid_rst", 1'b0, 1'b1);
    check_eq("mid_rst_y4_low", y4, 1'b0);
    run("post_rst", 1'b1, 16);

    // Randomized runs of levels with occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        step("rand_rst", 1'b0, 1'($urandom_range(0, 1)));
      end
      run("rand", 1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 25_000_000, board clock frequency in Hz (documentation and derivation only).
REQ-002 SHALL have parameter HALF_PERIOD, default 12_500_000, number of clock cycles per LED half-period (1 Hz blink at 25 MHz); legal range is at least 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 250_000, the stability window in cycles (10 ms at 25 MHz); legal range is at least 1.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have port a, input, 1 bit, asynchronous blink-enable level (button/switch).
REQ-007 SHALL have port y, output, 1 bit, registered LED drive.

Function
REQ-008 SHALL pass a through a 2-flop synchronizer (s1, s2) before any other use.
REQ-009 SHALL derive the internal enable en from s2: equal to s2 without DEBOUNCE_EN, or the debounced level with it (REQ-020).
REQ-010 SHALL, while en=0, hold the blink counter at 0, hold phase at 1 and drive y=0 from the next edge.
REQ-011 SHALL, while en=1, increment the counter each cycle; when count = HALF_PERIOD-1, wrap it to 0 and toggle phase in the same edge.
REQ-012 SHALL register y as en AND phase, so y=1 on the first edge with en=1, giving exactly HALF_PERIOD cycles high, then HALF_PERIOD cycles low, repeating.
REQ-013 SHALL size the counter width as ceil(log2(HALF_PERIOD)); the counter never exceeds HALF_PERIOD-1.
REQ-014 SHALL, with DEBOUNCE_EN undefined, make y rise on the 3rd rising edge after the first edge that samples a=1 (two synchronizer stages plus the output register).
REQ-015 SHALL, when en falls mid-period, clear y on the next edge and restart with a full high half-period on re-enable (no phase memory).
REQ-016 SHALL treat a glitch shorter than one cycle as either missed or captured by s1, and SHALL never produce metastable-dependent multi-bit state.

Reset
REQ-017 SHALL, on a rising edge with rst_n=0, set s1=s2=0, debounced level=0, debounce counter=0, blink counter=0, phase=1 and y=0.
REQ-018 SHALL let reset override all other activity, including mid-period and mid-debounce, with no state retained.
REQ-019 SHALL, when rst_n deasserts with a=1 held, follow REQ-014 or REQ-020 latency counted from the first non-reset edge.

Configuration
REQ-020 SHALL, with macro TOP_DEBOUNCE_EN defined, change the debounced level only after s2 has differed from it for DEBOUNCE_CYCLES consecutive edges; any sample equal to the level clears the debounce counter.
REQ-021 SHALL, without TOP_DEBOUNCE_EN, omit all debounce logic and use en = s2.

Structure
REQ-022 SHALL place the default constants (CLK_FREQ_HZ, HALF_PERIOD, DEBOUNCE_CYCLES defaults) in shared package top_pkg.
REQ-023 SHALL implement debouncing in one sub-module, debounce (ports clk, rst_n, din, dout), instantiated only under TOP_DEBOUNCE_EN; the synchronizer and blink counter stay in top.

Verification (HALF_PERIOD=4, DEBOUNCE_CYCLES=3 unless stated)
REQ-024 SHALL check reset: rst_n=0 for 2 edges with a=1 gives y=0 throughout.
REQ-025 SHALL check blink timing without debounce: a=1 from cycle 0 gives y=1 at edge 3, then 4 cycles high, 4 low, 4 high.
REQ-026 SHALL check disable mid-period: drop a during the 2nd high cycle; y=0 on the 3rd edge after, and re-enable restarts with 4 high cycles.
REQ-027 SHALL check debounce with TOP_DEBOUNCE_EN: a=1 pulse of 2 cycles leaves y=0; a=1 held gives y=1 at edge 6.
REQ-028 SHALL check reset mid-blink: rst_n=0 for 1 edge during the low half gives y=0, then with a=1 held, y=1 after REQ-014 latency.
REQ-029 SHALL check wrap-around: HALF_PERIOD=2 with a held gives y toggling every 2 cycles for 20 cycles with no drift.
